quiz_arbiter: RTL

QUIZ_ARBITER -- requirements
Module: quiz_arbiter

---
 rtl/quiz_arbiter_pkg.sv | 18 +
 rtl/quiz_arbiter_rr_pick4.sv | 26 ++
 rtl/quiz_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/quiz_arbiter_pkg.sv
// Shared definitions for the quiz arbiter: state encoding, default answer
// window length and the saturating score increment.
package quiz_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    ANSWER = 2'b10
  } state_t;

  localparam int DEFAULT_TIMEOUT = 16;

  // Scores are 4 bits wide and stop at 15 rather than wrapping
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/quiz_arbiter_rr_pick4.sv
// Round-robin picker over four requesters. The search starts at ptr and
// walks upward modulo 4; the first asserted request wins. Purely combinational.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       valid
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest requester is kept last
  always_comb begin
    idx   = ptr;
    valid = 1'b0;
    cand  = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quiz_arbiter.sv
// Quiz-show buzzer arbiter. The host opens a question, the first contestant
// to press (round-robin on ties) gets the floor, and the host judges the
// answer or lets the window expire. Wrong answers lock the player out.
module quiz_arbiter
  import quiz_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int NPLAYER = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPLAYER-1:0]     buzz,
  input  logic                   host_start,
  input  logic                   host_correct,
  input  logic                   host_wrong,
  input  logic                   host_abort,
  output logic [NPLAYER-1:0]     led,
  output logic                   armed,
  output logic [NPLAYER-1:0]     lock,
  output logic                   timeout,
  output logic [4*NPLAYER-1:0]   score
);

  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT - 1);

  state_t             state, state_next;
  logic [NPLAYER-1:0] buzz_q, buzz_edge, buzz_ev, winner_oh;
  logic [1:0]         rr, winner, pick_idx;
  logic               pick_valid;
  logic [7:0]         timer;
  logic               do_grant, do_correct, do_fail, do_expire, do_clear, do_bad;

  assign buzz_edge = buzz & ~buzz_q;
  assign buzz_ev   = buzz_edge & ~lock;
  assign winner_oh = NPLAYER'(1) << winner;

  rr_pick4 u_pick (
    .req   (buzz_ev),
    .ptr   (rr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Previous button levels, tracked in every state so a held button never re-fires
  always_ff @(posedge clk) begin
    if (!rst_n) buzz_q <= '0;
    else        buzz_q <= buzz;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and datapath strobes; abort beats correct beats wrong/expiry
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_correct = 1'b0;
    do_fail    = 1'b0;
    do_expire  = 1'b0;
    do_clear   = 1'b0;
    do_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (host_start) begin
          state_next = ARMED;
          do_clear   = 1'b1;
        end
      end
      ARMED: begin
        if (host_abort) begin
          state_next = IDLE;
        end else if (pick_valid) begin
          state_next = ANSWER;
          do_grant   = 1'b1;
        end
      end
      ANSWER: begin
        if (host_abort) begin
          state_next = IDLE;
        end else if (host_correct) begin
          state_next = IDLE;
          do_correct = 1'b1;
        end else if (host_wrong || timer == 8'd0) begin
          do_fail    = 1'b1;
          do_expire  = !host_wrong;
          state_next = ((lock | winner_oh) == {NPLAYER{1'b1}}) ? IDLE : ARMED;
        end
      end
      default: begin
        state_next = IDLE;
        do_bad     = 1'b1;
      end
    endcase
  end

  // Decode the floor indicator and armed flag from the registered state
  always_comb begin
    led   = (state == ANSWER) ? winner_oh : '0;
    armed = (state == ARMED);
  end

  // Grant bookkeeping: winner, round-robin pointer and answer-window timer
  always_ff @(posedge clk) begin
    if (!rst_n || do_bad) begin
      winner <= 2'd0;
      rr     <= 2'd0;
      timer  <= 8'd0;
    end else if (do_grant) begin
      winner <= pick_idx;
      rr     <= pick_idx + 2'd1;
      timer  <= TIMER_LOAD;
    end else if (state == ANSWER) begin
      timer  <= timer - 8'd1;
    end
  end

  // Lockout mask, expiry pulse and saturating scores
  always_ff @(posedge clk) begin
    if (!rst_n || do_bad) begin
      lock    <= '0;
      timeout <= 1'b0;
      score   <= '0;
    end else begin
      timeout <= do_expire;
      if (do_clear)     lock <= '0;
      else if (do_fail) lock <= lock | winner_oh;
      for (int i = 0; i < NPLAYER; i++) begin
        if (do_correct && winner == 2'(i))
          score[4*i +: 4] <= sat_inc4(score[4*i +: 4]);
      end
    end
  end

endmodule
